// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one UART TX byte port between NREQ requesters.
// It also owns the baud setting and applies a baud change only while the transmitter is idle.
module uart_tx_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned GAP     = 4,
  parameter int unsigned SETTLE  = 16,
  parameter int unsigned TIMEOUT = 2000000,
  localparam int unsigned IW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [IW-1:0]      grant_id,
  input  logic               cfg_baud_wr,
  input  logic [16:0]        cfg_baud,
  output logic               cfg_pending,
  output logic               cfg_err,
  output logic [16:0]        baud,
  output logic               tx_start,
  output logic [DW-1:0]      tx_data,
  input  logic               tx_busy,
  input  logic               tx_done,
  output logic               err_timeout
);

  localparam int unsigned CMAX0 = (GAP > SETTLE) ? GAP : SETTLE;
  localparam int unsigned CMAX  = (TIMEOUT > CMAX0) ? TIMEOUT : CMAX0;
  localparam int unsigned CW    = $clog2(CMAX + 1);

  typedef enum logic [2:0] {StIdle, StStart, StWait, StGap, StCfg} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [IW-1:0]   last_q;
  logic [16:0]     pend_q;

  logic            baud_ok;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [DW-1:0]   pick_data;
  logic            to_hit;

  always_comb begin
    case (cfg_baud)
      17'd4800, 17'd9600, 17'd14400, 17'd19200,
      17'd38400, 17'd57600, 17'd115200, 17'd128000: baud_ok = 1'b1;
      default:                                      baud_ok = 1'b0;
    endcase
  end

  // Search last+1, last+2, ... with an explicit wrap so non-power-of-two NREQ works.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_data  = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      int j;
      j = int'(last_q) + k;
      if (j >= int'(NREQ)) j = j - int'(NREQ);
      if (!pick_valid && req_valid[j]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'(j);
        pick_data  = req_data[j*DW +: DW];
      end
    end
  end

  assign to_hit = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      last_q      <= IW'(NREQ - 1);
      pend_q      <= 17'd9600;
      baud        <= 17'd9600;
      cfg_pending <= 1'b0;
      cfg_err     <= 1'b0;
      req_ready   <= '0;
      grant_id    <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      err_timeout <= 1'b0;
    end else begin
      req_ready   <= '0;
      cfg_err     <= 1'b0;
      err_timeout <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (cfg_pending) begin
            baud        <= pend_q;
            cfg_pending <= 1'b0;
            cnt_q       <= '0;
            state_q     <= StCfg;
          end else if (pick_valid && !tx_busy) begin
            req_ready[pick_idx] <= 1'b1;
            tx_data             <= pick_data;
            tx_start            <= 1'b1;
            grant_id            <= pick_idx;
            last_q              <= pick_idx;
            cnt_q               <= '0;
            state_q             <= StStart;
          end
        end
        StStart: begin
          if (tx_done) begin
            tx_start <= 1'b0;
            cnt_q    <= '0;
            state_q  <= StGap;
          end else if (tx_busy) begin
            tx_start <= 1'b0;
            cnt_q    <= cnt_q + CW'(1);
            state_q  <= StWait;
          end else if (to_hit) begin
            err_timeout <= 1'b1;
            tx_start    <= 1'b0;
            cnt_q       <= '0;
            state_q     <= StGap;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StWait: begin
          if (tx_done || !tx_busy) begin
            cnt_q   <= '0;
            state_q <= StGap;
          end else if (to_hit) begin
            err_timeout <= 1'b1;
            cnt_q       <= '0;
            state_q     <= StGap;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StGap: begin
          if (cnt_q == CW'(GAP - 1)) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StCfg: begin
          if (cnt_q == CW'(SETTLE - 1)) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase

      // A write in the same cycle as the baud apply stays pending (last write wins).
      if (cfg_baud_wr) begin
        if (baud_ok) begin
          pend_q      <= cfg_baud;
          cfg_pending <= 1'b1;
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: a vector table for reset/config/first grant,
// then hand-written sequences for timeout, fairness, deferred baud and reset mid-frame.
module tb_uart_tx_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [1:0]        grant_id;
  logic              cfg_baud_wr;
  logic [16:0]       cfg_baud;
  logic              cfg_pending;
  logic              cfg_err;
  logic [16:0]       baud;
  logic              tx_start;
  logic [DW-1:0]     tx_data;
  logic              tx_busy;
  logic              tx_done;
  logic              err_timeout;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_sched #(
    .NREQ    (NREQ),
    .DW      (DW),
    .GAP     (4),
    .SETTLE  (16),
    .TIMEOUT (50)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .grant_id    (grant_id),
    .cfg_baud_wr (cfg_baud_wr),
    .cfg_baud    (cfg_baud),
    .cfg_pending (cfg_pending),
    .cfg_err     (cfg_err),
    .baud        (baud),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .err_timeout (err_timeout)
  );

  // TX core model: when enabled, busy for 10 cycles after seeing tx_start, then a done pulse.
  logic tx_en;
  int   fcnt;
  always @(posedge clk) begin
    tx_done <= 1'b0;
    if (!rst || !tx_en) begin
      tx_busy <= 1'b0;
      fcnt    <= 0;
    end else if (!tx_busy && tx_start) begin
      tx_busy <= 1'b1;
      fcnt    <= 10;
    end else if (tx_busy) begin
      if (fcnt == 1) begin
        tx_busy <= 1'b0;
        tx_done <= 1'b1;
      end else begin
        fcnt <= fcnt - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic expired(input string name);
    checks++;
    failures++;
    $display("FAIL %s wait bound expired", name);
  endtask

  typedef struct {
    logic        rst;
    logic        wr;
    logic [16:0] cb;
    logic [3:0]  valid;
    logic [16:0] e_baud;
    logic        e_pend;
    logic        e_err;
    logic [3:0]  e_rdy;
    logic        e_start;
    logic [1:0]  e_gid;
    logic [7:0]  e_data;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int  t_grant, t_to, t_baud, t_prev;
    bit  ok;
    int  exp_order[6];

    rst         = 1'b0;
    req_valid   = '0;
    req_data    = {8'hD3, 8'hA5, 8'hC1, 8'hB0};
    cfg_baud_wr = 1'b0;
    cfg_baud    = '0;
    tx_en       = 1'b0;

    //            rst   wr    cb          valid    baud        pend  err   rdy      st    gid    data
    tbl[0] = '{1'b0, 1'b0, 17'd0,     4'b0000, 17'd9600, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00};
    tbl[1] = '{1'b0, 1'b0, 17'd0,     4'b0000, 17'd9600, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00};
    tbl[2] = '{1'b0, 1'b0, 17'd0,     4'b0000, 17'd9600, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00};
    tbl[3] = '{1'b1, 1'b1, 17'd12345, 4'b0000, 17'd9600, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
    tbl[4] = '{1'b1, 1'b0, 17'd0,     4'b0000, 17'd9600, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00};
    tbl[5] = '{1'b1, 1'b0, 17'd0,     4'b0100, 17'd9600, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 8'hA5};
    tbl[6] = '{1'b1, 1'b0, 17'd0,     4'b0000, 17'd9600, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA5};
    tbl[7] = '{1'b1, 1'b1, 17'd4800,  4'b0000, 17'd9600, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA5};
    tbl[8] = '{1'b1, 1'b1, 17'd57600, 4'b0000, 17'd9600, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA5};
    tbl[9] = '{1'b1, 1'b0, 17'd0,     4'b0000, 17'd9600, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA5};

    t_grant = 0;
    for (int i = 0; i < 10; i++) begin
      rst         = tbl[i].rst;
      cfg_baud_wr = tbl[i].wr;
      cfg_baud    = tbl[i].cb;
      req_valid   = tbl[i].valid;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_baud", i), 32'(baud), 32'(tbl[i].e_baud));
      chk($sformatf("v%0d_pend", i), 32'(cfg_pending), 32'(tbl[i].e_pend));
      chk($sformatf("v%0d_err", i), 32'(cfg_err), 32'(tbl[i].e_err));
      chk($sformatf("v%0d_rdy", i), 32'(req_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("v%0d_start", i), 32'(tx_start), 32'(tbl[i].e_start));
      chk($sformatf("v%0d_gid", i), 32'(grant_id), 32'(tbl[i].e_gid));
      chk($sformatf("v%0d_data", i), 32'(tx_data), 32'(tbl[i].e_data));
      if (i == 5) t_grant = cyc;
    end
    cfg_baud_wr = 1'b0;
    req_valid   = 4'b1010;

    // Timeout: core never goes busy, abort 50 cycles after the grant.
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      #1;
      if (err_timeout) begin ok = 1'b1; break; end
    end
    if (!ok) expired("timeout_pulse");
    t_to = cyc;
    chk("timeout_latency", 32'(t_to - t_grant), 32'd50);
    chk("timeout_start_low", 32'(tx_start), 32'd0);
    @(posedge clk);
    #1;
    chk("timeout_one_cycle", 32'(err_timeout), 32'd0);

    // Pending baud (last write 57600) applies after GAP, beating the pending requests.
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (baud != 17'd9600) begin ok = 1'b1; break; end
      @(posedge clk);
      #1;
    end
    if (!ok) expired("baud_apply");
    t_baud = cyc;
    chk("baud_last_wins", 32'(baud), 32'd57600);
    chk("baud_after_gap", 32'(t_baud - t_to), 32'd5);
    chk("pend_cleared", 32'(cfg_pending), 32'd0);

    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      #1;
      if (req_ready != 0) begin ok = 1'b1; break; end
    end
    if (!ok) expired("grant_after_settle");
    chk("settle_latency", 32'(cyc - t_baud), 32'd17);
    chk("rr_after_to_rdy", 32'(req_ready), 32'b1000);
    chk("rr_after_to_gid", 32'(grant_id), 32'd3);
    chk("rr_after_to_data", 32'(tx_data), 32'hD3);

    // Fairness with a working core model.
    req_valid = '0;
    rst       = 1'b0;
    tx_en     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset2_baud", 32'(baud), 32'd9600);
    rst       = 1'b1;
    req_valid = 4'b1111;
    exp_order = '{0, 1, 2, 3, 0, 1};
    t_prev    = 0;
    for (int g = 0; g < 6; g++) begin
      ok = 1'b0;
      for (int n = 0; n < 100; n++) begin
        @(posedge clk);
        #1;
        if (req_ready != 0) begin ok = 1'b1; break; end
      end
      if (!ok) expired($sformatf("fair%0d_wait", g));
      chk($sformatf("fair%0d_rdy", g), 32'(req_ready), 32'(1) << exp_order[g]);
      chk($sformatf("fair%0d_gid", g), 32'(grant_id), 32'(exp_order[g]));
      chk($sformatf("fair%0d_data", g), 32'(tx_data), 32'(req_data[exp_order[g]*DW +: DW]));
      if (g > 0) chk($sformatf("fair%0d_spacing", g), 32'((cyc - t_prev) >= 15), 32'd1);
      t_prev = cyc;
    end

    // Deferred baud: write mid-frame, applied only after the frame and the gap.
    repeat (3) @(posedge clk);
    #1;
    cfg_baud_wr = 1'b1;
    cfg_baud    = 17'd115200;
    @(posedge clk);
    #1;
    cfg_baud_wr = 1'b0;
    chk("defer_pend", 32'(cfg_pending), 32'd1);
    chk("defer_baud_old", 32'(baud), 32'd9600);
    chk("defer_busy", 32'(tx_busy), 32'd1);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      #1;
      if (baud != 17'd9600) begin ok = 1'b1; break; end
    end
    if (!ok) expired("defer_apply");
    t_baud = cyc;
    chk("defer_baud_new", 32'(baud), 32'd115200);
    chk("defer_idle", 32'(tx_busy), 32'd0);
    chk("defer_latency", 32'(t_baud - t_prev), 32'd17);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      #1;
      if (req_ready != 0) begin ok = 1'b1; break; end
    end
    if (!ok) expired("defer_grant");
    chk("defer_settle", 32'(cyc - t_baud), 32'd17);
    chk("defer_gid", 32'(grant_id), 32'd2);

    // Reset while the core is busy, then requester 1 alone is re-granted.
    repeat (4) @(posedge clk);
    #1;
    chk("midframe_busy", 32'(tx_busy), 32'd1);
    req_valid = 4'b0010;
    rst       = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_rdy", 32'(req_ready), 32'd0);
    chk("mrst_start", 32'(tx_start), 32'd0);
    chk("mrst_gid", 32'(grant_id), 32'd0);
    chk("mrst_data", 32'(tx_data), 32'd0);
    chk("mrst_baud", 32'(baud), 32'd9600);
    chk("mrst_pend", 32'(cfg_pending), 32'd0);
    chk("mrst_to", 32'(err_timeout), 32'd0);
    rst = 1'b1;
    ok  = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      #1;
      if (req_ready != 0) begin ok = 1'b1; break; end
    end
    if (!ok) expired("regrant_wait");
    chk("regrant_rdy", 32'(req_ready), 32'b0010);
    chk("regrant_gid", 32'(grant_id), 32'd1);
    chk("regrant_data", 32'(tx_data), 32'hC1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
